// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register built as a two-entry skid buffer.
// The main entry drives out_*. The skid entry absorbs one instruction when
// decode stalls, so in_ready depends only on registered state.
// The immediate-format select is decoded at capture and stored with each entry.
// Optional feature macro: ILLEGAL_CHECK_EN adds the out_illegal flag and its storage.
module if_id_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic [24:0]     out_imm_field,
  output logic [4:0]      out_sext_ope
`ifdef ILLEGAL_CHECK_EN
  ,
  output logic            out_illegal
`endif
);

  // Immediate format selects shared with the immediate generator (one-hot).
  localparam logic [4:0] IMM_I = 5'b00001;
  localparam logic [4:0] IMM_S = 5'b00010;
  localparam logic [4:0] IMM_B = 5'b00100;
  localparam logic [4:0] IMM_J = 5'b01000;
  localparam logic [4:0] IMM_U = 5'b10000;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_reg;
  state_t state_next;

  logic            accept;
  logic            drain;
  logic            load_main_in;
  logic            load_main_skid;
  logic            load_skid;

  logic [XLEN-1:0] main_pc_reg;
  logic [XLEN-1:0] main_inst_reg;
  logic [4:0]      main_sext_reg;
  logic [XLEN-1:0] skid_pc_reg;
  logic [XLEN-1:0] skid_inst_reg;
  logic [4:0]      skid_sext_reg;
  logic [4:0]      in_sext;

  // Map an opcode to its immediate format; non-immediate opcodes give 0.
  function automatic logic [4:0] decode_sext(input logic [6:0] opcode);
    logic [4:0] sel;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: sel = IMM_I;
      7'b0100011:                                     sel = IMM_S;
      7'b1100011:                                     sel = IMM_B;
      7'b1101111:                                     sel = IMM_J;
      7'b0110111, 7'b0010111:                         sel = IMM_U;
      default:                                        sel = 5'd0;
    endcase
    return sel;
  endfunction

  assign in_sext = decode_sext(in_inst[6:0]);
  assign accept  = in_valid && in_ready;
  assign drain   = out_valid && out_ready;

  // State register: an asynchronous reset drops every buffered entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and entry-movement decisions; flush overrides accept and drain.
  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY: begin
          if (accept) begin
            state_next   = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_next = TWO;
            load_skid  = 1'b1;
          end else if (drain) begin
            state_next = EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so the only event is a drain.
          if (drain) begin
            state_next     = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  // Handshake outputs are decoded from the registered state only.
  always_comb begin
    in_ready  = (state_reg != TWO);
    out_valid = (state_reg != EMPTY);
  end

  // Entry storage: main is loaded from fetch or from skid, and skid only from fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_pc_reg   <= '0;
      main_inst_reg <= '0;
      main_sext_reg <= '0;
      skid_pc_reg   <= '0;
      skid_inst_reg <= '0;
      skid_sext_reg <= '0;
    end else begin
      if (load_main_in) begin
        main_pc_reg   <= in_pc;
        main_inst_reg <= in_inst;
        main_sext_reg <= in_sext;
      end else if (load_main_skid) begin
        main_pc_reg   <= skid_pc_reg;
        main_inst_reg <= skid_inst_reg;
        main_sext_reg <= skid_sext_reg;
      end
      if (load_skid) begin
        skid_pc_reg   <= in_pc;
        skid_inst_reg <= in_inst;
        skid_sext_reg <= in_sext;
      end
    end
  end

`ifdef ILLEGAL_CHECK_EN
  logic main_illegal_reg;
  logic skid_illegal_reg;
  logic in_illegal;

  // Illegal: an opcode that is neither immediate-bearing nor R-type, or a non-32-bit encoding.
  assign in_illegal = ((in_sext == 5'd0) && (in_inst[6:0] != 7'b0110011)) ||
                      (in_inst[1:0] != 2'b11);

  // The illegal flag travels with its entry exactly like the other fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_illegal_reg <= 1'b0;
      skid_illegal_reg <= 1'b0;
    end else begin
      if (load_main_in) begin
        main_illegal_reg <= in_illegal;
      end else if (load_main_skid) begin
        main_illegal_reg <= skid_illegal_reg;
      end
      if (load_skid) begin
        skid_illegal_reg <= in_illegal;
      end
    end
  end

  assign out_illegal = main_illegal_reg;
`endif

  assign out_pc        = main_pc_reg;
  assign out_inst      = main_inst_reg;
  assign out_imm_field = main_inst_reg[31:7];
  assign out_sext_ope  = main_sext_reg;

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed bench for if_id_stage.
// The reference is an in-order queue of at most two entries that holds whatever
// the stage currently has. A negedge compare process checks every output
// against it, and directed literal checks pin the expected values.
// Build with ILLEGAL_CHECK_EN defined to exercise out_illegal as well.
module tb_if_id_stage;

  localparam logic [4:0] IMM_I = 5'b00001;
  localparam logic [4:0] IMM_S = 5'b00010;
  localparam logic [4:0] IMM_B = 5'b00100;
  localparam logic [4:0] IMM_J = 5'b01000;
  localparam logic [4:0] IMM_U = 5'b10000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_inst = '0;
  logic [31:0] in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [24:0] out_imm_field;
  logic [4:0]  out_sext_ope;
`ifdef ILLEGAL_CHECK_EN
  logic        out_illegal;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t model_q[$];
  bit   model_take;

  if_id_stage #(.XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_inst       (in_inst),
    .in_pc         (in_pc),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_inst      (out_inst),
    .out_imm_field (out_imm_field),
    .out_sext_ope  (out_sext_ope)
`ifdef ILLEGAL_CHECK_EN
    ,
    .out_illegal   (out_illegal)
`endif
  );

  always #5 clk = ~clk;

  // Immediate format from the opcode table.
  function automatic logic [4:0] exp_sext(input logic [31:0] inst);
    logic [4:0] r;
    case (inst[6:0])
      7'h13, 7'h03, 7'h67, 7'h73: r = IMM_I;
      7'h23:                      r = IMM_S;
      7'h63:                      r = IMM_B;
      7'h6F:                      r = IMM_J;
      7'h37, 7'h17:               r = IMM_U;
      default:                    r = 5'd0;
    endcase
    return r;
  endfunction

  function automatic logic exp_illegal(input logic [31:0] inst);
    return ((exp_sext(inst) == 5'd0) && (inst[6:0] != 7'h33)) || (inst[1:0] != 2'b11);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a FIFO of what the stage holds (capacity two).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      model_take = (model_q.size() < 2);
      if (model_q.size() > 0 && out_ready) begin
        $display("xfer pc=%h inst=%h", model_q[0].pc, model_q[0].inst);
        void'(model_q.pop_front());
      end
      if (in_valid && model_take) begin
        model_q.push_back('{pc: in_pc, inst: in_inst});
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_pc", out_pc, 32'd0);
      chk("rst_out_inst", out_inst, 32'd0);
      chk("rst_out_sext", {27'd0, out_sext_ope}, 32'd0);
    end else begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, model_q.size() < 2});
      chk("out_valid", {31'd0, out_valid}, {31'd0, model_q.size() != 0});
      if (model_q.size() != 0) begin
        chk("out_pc", out_pc, model_q[0].pc);
        chk("out_inst", out_inst, model_q[0].inst);
        chk("out_imm_field", {7'd0, out_imm_field}, {7'd0, model_q[0].inst[31:7]});
        chk("out_sext_ope", {27'd0, out_sext_ope}, {27'd0, exp_sext(model_q[0].inst)});
`ifdef ILLEGAL_CHECK_EN
        chk("out_illegal", {31'd0, out_illegal}, {31'd0, exp_illegal(model_q[0].inst)});
`endif
      end
    end
  end

  logic [31:0] dec_inst [5] = '{32'hFE000EE3, 32'h008000EF, 32'h000012B7, 32'h00112023, 32'h002081B3};
  logic [4:0]  dec_sext [5] = '{IMM_B, IMM_J, IMM_U, IMM_S, 5'd0};

  initial begin
    repeat (2) step();
    #2 rst_n = 1'b1;
    step();

    // Single addi with decode ready.
    in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h0; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("addi_valid", {31'd0, out_valid}, 32'd1);
    chk("addi_sext", {27'd0, out_sext_ope}, {27'd0, IMM_I});
    chk("addi_imm", {7'd0, out_imm_field}, 32'h0000A001);
    step();

    // Decode table for each format, streamed back-to-back.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_inst = dec_inst[i]; in_pc = 32'h40 + 32'(i * 4);
      step();
      chk("fmt_sext", {27'd0, out_sext_ope}, {27'd0, dec_sext[i]});
      chk("fmt_pc", out_pc, 32'h40 + 32'(i * 4));
    end
    in_valid = 1'b0; in_inst = 32'hDEADBEEF; in_pc = 32'hFFFF_FFF0;
    step();
    step();

    // Stall: two accepted, the third held by fetch, then ordered release.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h0;
    step();
    chk("stall_ready1", {31'd0, in_ready}, 32'd1);
    in_inst = 32'h00200113; in_pc = 32'h4;
    step();
    chk("stall_ready2", {31'd0, in_ready}, 32'd0);
    in_inst = 32'h00300193; in_pc = 32'h8;
    step();
    chk("stall_hold_pc", out_pc, 32'h0);
    out_ready = 1'b1;
    step();
    chk("release_pc4", out_pc, 32'h4);
    chk("release_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("release_pc8", out_pc, 32'h8);
    in_valid = 1'b0;
    step();
    chk("release_empty", {31'd0, out_valid}, 32'd0);

    // Flush while full with a same-cycle incoming beat.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h100;
    step();
    in_inst = 32'h00200113; in_pc = 32'h104;
    step();
    in_inst = 32'h00300193; in_pc = 32'h108; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    repeat (3) step();
    chk("flush_none", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset between edges while full.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h00100093; in_pc = 32'h300;
    step();
    in_inst = 32'h00200113; in_pc = 32'h304;
    step();
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_pc", out_pc, 32'd0);
    chk("arst_inst", out_inst, 32'd0);
    step();
    #2 rst_n = 1'b1;
    in_valid = 1'b1; in_inst = 32'h00000037; in_pc = 32'h200;
    step();
    in_valid = 1'b0;
    chk("post_rst_pc", out_pc, 32'h200);
    chk("post_rst_sext", {27'd0, out_sext_ope}, {27'd0, IMM_U});
    out_ready = 1'b1;
    step();

`ifdef ILLEGAL_CHECK_EN
    in_valid = 1'b1; in_inst = 32'h0000007F; in_pc = 32'h500;
    step();
    chk("illegal_set", {31'd0, out_illegal}, 32'd1);
    chk("illegal_sext", {27'd0, out_sext_ope}, 32'd0);
    in_inst = 32'h002081B3; in_pc = 32'h504;
    step();
    chk("illegal_clr", {31'd0, out_illegal}, 32'd0);
    in_valid = 1'b0;
    step();
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the PC and instruction width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  fetch presents an instruction.
REQ-005 SHALL have port in_ready  output  1  stage can accept; transfer occurs when in_valid&&in_ready.
REQ-006 SHALL have port in_inst  input  32  fetched instruction word.
REQ-007 SHALL have port in_pc  input  32  PC of in_inst.
REQ-008 SHALL have port flush  input  1  discard all held and incoming instructions (branch redirect).
REQ-009 SHALL have port out_valid  output  1  decode-side entry valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts; transfer occurs when out_valid&&out_ready.
REQ-011 SHALL have port out_pc  output  32  PC of the presented entry.
REQ-012 SHALL have port out_inst  output  32  full instruction word of the presented entry.
REQ-013 SHALL have port out_imm_field  output  25  bits [31:7] of out_inst, the immediate-generator imm input.
REQ-014 SHALL have port out_sext_ope  output  5  immediate format select, driven as IMM_I/IMM_S/IMM_B/IMM_J/IMM_U from the shared parameter header, or 0.
REQ-015 SHALL have port out_illegal  output  1  presented entry has an unrecognised opcode (present only with ILLEGAL_CHECK_EN).

Function
REQ-016 SHALL be a two-entry skid buffer (main, skid) with states EMPTY, ONE, TWO; output always reflects main.
REQ-017 SHALL drive in_ready = (state != TWO), decoded from registered state only; no combinational path from out_ready to in_ready.
REQ-018 SHALL transition EMPTY->ONE on accept; ONE->ONE on accept with drain or neither; ONE->EMPTY on drain only; ONE->TWO on accept without drain (new entry to skid); TWO->ONE on drain (skid moves to main).
REQ-019 SHALL present a newly accepted instruction on out_* the cycle after acceptance (1-cycle latency) when buffer was EMPTY or drained the same cycle.
REQ-020 SHALL compute out_sext_ope from opcode [6:0] at capture and store it with the entry: 0010011, 0000011, 1100111, 1110011 -> IMM_I; 0100011 -> IMM_S; 1100011 -> IMM_B; 1101111 -> IMM_J; 0110111, 0010111 -> IMM_U; all others -> 0.
REQ-021 SHALL preserve order: the entry in skid never overtakes main.
REQ-022 SHALL, when flush is high, go to EMPTY next cycle, drop any same-cycle accepted instruction, and hold out_valid low; flush has priority over accept and drain.
REQ-023 SHALL hold out_* stable while out_valid&&!out_ready.
REQ-024 SHALL ignore in_inst/in_pc when in_valid is low.

Reset
REQ-025 SHALL on rst_n low asynchronously enter EMPTY and clear out_valid, out_pc, out_inst, out_imm_field, out_sext_ope, out_illegal to 0, with in_ready=1.
REQ-026 SHALL discard any buffered entries when reset asserts mid-operation; first accept after release behaves as from EMPTY.

Configuration
REQ-027 SHALL with macro ILLEGAL_CHECK_EN defined provide out_illegal, set for an entry whose opcode is not in REQ-020's list and not 0110011 (R-type), or whose bits [1:0] != 2'b11.
REQ-028 SHALL without ILLEGAL_CHECK_EN omit the out_illegal port and its storage; all other behaviour identical.

Verification
REQ-029 SHALL cover: reset release, in_valid=1 inst=32'h00500093 pc=0, out_ready=1 -> next cycle out_valid=1, out_sext_ope=IMM_I, out_imm_field=25'h00A001.
REQ-030 SHALL cover: out_ready=0, three back-to-back in_valid beats -> first two accepted, in_ready=0 after second, third held by fetch; release out_ready -> outputs in order pc 0,4,8.
REQ-031 SHALL cover: state TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, none of the three instructions ever emerge.
REQ-032 SHALL cover: inst 32'hFE000EE3 (beq) -> IMM_B; 32'h008000EF (jal) -> IMM_J; 32'h000012B7 (lui) -> IMM_U; 32'h00112023 (sw) -> IMM_S; 32'h002081B3 (add) -> 0.
REQ-033 SHALL cover: with ILLEGAL_CHECK_EN, inst 32'h0000007F -> out_illegal=1, out_sext_ope=0; inst 32'h002081B3 -> out_illegal=0.
REQ-034 SHALL cover: rst_n asserted asynchronously between clock edges while in TWO -> outputs clear immediately, in_ready=1.
